// File: rtl/halfband_seq_pkg.sv
// Shared constants and types for the half-band phase sequencer and frame assembler.
package halfband_seq_pkg;

  localparam int LAT_DEF  = 5;
  localparam int WARM_DEF = 16;

  localparam logic [1:0] PH_A0 = 2'd0;
  localparam logic [1:0] PH_A1 = 2'd1;
  localparam logic [1:0] PH_B0 = 2'd2;
  localparam logic [1:0] PH_B1 = 2'd3;

  localparam logic signed [16:0] CLIP_HI = 17'sh0ffff;
  localparam logic signed [16:0] CLIP_LO = 17'sh10000;

  // wok: warm-up had expired when this phase was issued to the filter
  typedef struct packed {
    logic       vld;
    logic       wok;
    logic [1:0] ph;
  } tag_t;

  function automatic logic is_clip(input logic signed [16:0] v);
    return (v == CLIP_HI) || (v == CLIP_LO);
  endfunction

endpackage

// File: rtl/halfband_seq_tag_delay.sv
// Fixed-length tag delay line, len cycles from data to delayed; no backpressure.
// flush zeroes every stage, including the word presented this cycle.
module tag_delay #(
  parameter int dw  = 4,
  parameter int len = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [dw-1:0] data,
  output logic [dw-1:0] delayed
);

  logic [dw-1:0] stage [len];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < len; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < len; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < len; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[len-1];

endmodule

// File: rtl/halfband_seq.sv
// Drives the filter's A/B select and assembles its LAT-delayed results into 4-slot frames.
// Frame strobe one cycle after the phase-3 capture; no backpressure, enable low stalls the phase.
module halfband_seq
  import halfband_seq_pkg::*;
#(
  parameter int LAT  = LAT_DEF,
  parameter int WARM = WARM_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sync,
  output logic               ab,
  input  logic signed [16:0] d,
  input  logic               clr_clip,
  output logic signed [16:0] fa0,
  output logic signed [16:0] fa1,
  output logic signed [16:0] fb0,
  output logic signed [16:0] fb1,
  output logic               frame_valid,
  output logic [15:0]        frame_cnt,
  output logic               clip
);

  localparam logic [15:0] WARM_LD = 16'(WARM);

  logic [1:0]  ph;
  logic [1:0]  ph_nxt;
  logic        enable_q;
  logic [15:0] warm;
  logic [3:0]  mask;
  logic        frame_ok;
  tag_t        tag_in;
  tag_t        tag_out;
  logic        cap;
  logic        last;
  logic        emit;
  logic        clip_hit;

  always_comb begin
    ph_nxt = ph;
    if (sync)        ph_nxt = PH_A0;
    else if (enable) ph_nxt = ph + 2'd1;
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = enable;
    tag_in.wok = (warm == 16'd0);
    tag_in.ph  = ph;
  end

  tag_delay #(
    .dw  ($bits(tag_t)),
    .len (LAT)
  ) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (sync),
    .data    (tag_in),
    .delayed (tag_out)
  );

  // A frame only counts if its first sample was issued after warm-up; the
  // tags of a frame are contiguous, so checking phase 0 covers all four.
  assign cap      = tag_out.vld && !sync;
  assign last     = cap && (tag_out.ph == PH_B1);
  assign emit     = last && (mask == 4'b0111) && frame_ok;
  assign clip_hit = cap && is_clip(d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= PH_A0;
      ab       <= 1'b0;
      enable_q <= 1'b0;
      warm     <= WARM_LD;
    end else begin
      ph       <= ph_nxt;
      ab       <= ph_nxt[1];
      enable_q <= enable;
      if (sync || (enable && !enable_q)) warm <= WARM_LD;
      else if (enable && warm != 16'd0)  warm <= warm - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      frame_ok    <= 1'b0;
      fa0         <= '0;
      fa1         <= '0;
      fb0         <= '0;
      fb1         <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      clip        <= 1'b0;
    end else begin
      frame_valid <= emit;
      frame_cnt   <= frame_cnt + {15'd0, emit};

      if (!cap || last) mask <= '0;
      else              mask <= mask | (4'b0001 << tag_out.ph);

      if (cap) begin
        case (tag_out.ph)
          PH_A0: begin
            fa0      <= d;
            frame_ok <= tag_out.wok;
          end
          PH_A1:   fa1 <= d;
          PH_B0:   fb0 <= d;
          default: fb1 <= d;
        endcase
      end

      if (clip_hit)      clip <= 1'b1;
      else if (clr_clip) clip <= 1'b0;
    end
  end

endmodule
